qos_csr_bank: RTL and testbench
===============================

# qos_csr_bank

Parametrised memory-mapped control/status block for the MPEG2-TS QoS controller, sitting between the host bus and the QoS core. Holds staged configuration that becomes active only on an explicit commit, counts per-channel TS errors internally with saturation, latches sticky signal-loss/saturation events with write-1-to-clear semantics, and raises a maskable interrupt. Read data returns with a fixed one-cycle latency and a valid/error strobe.

## Interface
Parameters:
- N_CH, 4, number of TS input channels (2..8)
- CH_W, 3, channel index width (must satisfy 2^CH_W >= N_CH; max 3)
- CNT_W, 8, per-channel error counter width (1..16)
- TIMER_W, 20, reset_timer width (1..24)
- TIMER_DEF, 1000000, reset value of staged and active reset_timer

Ports:
- clk  in  1  single clock; all logic on rising edge
- rst  in  1  asynchronous, active-low reset
- mm_write_en  in  1  write strobe, one access per cycle
- mm_read_en  in  1  read strobe
- mm_addr  in  8  word address
- mm_wdata  in  32  write data
- mm_rdata  out  32  read data, valid when mm_rdata_valid
- mm_rdata_valid  out  1  one-cycle pulse, read response
- mm_err  out  1  one-cycle pulse: access to unmapped or read-only address
- fallback_enable, manual_enable  out  1 each  active config
- manual_channel  out  CH_W  active config
- channel_priority  out  N_CH*CH_W  active config, channel i at [i*CH_W +: CH_W]
- reset_timer  out  TIMER_W  active config
- valid_config  out  1  one-cycle pulse after each commit
- irq  out  1  registered interrupt
- active_channel  in  CH_W  from QoS core
- signal_present  in  N_CH  from QoS core
- error_inc  in  N_CH  one-cycle pulse per detected TS error, per channel

## Operation
Register map (unused bits read 0, writes to them ignored):
- 0x00 CTRL RW (staged): [0] fallback_en, [1] manual_en, [2] irq_en, [4 +: CH_W] manual_channel
- 0x01 PRIO RW (staged): [N_CH*CH_W-1:0] channel_priority
- 0x02 TIMER RW (staged): [TIMER_W-1:0]
- 0x03 COMMIT WO: any write copies staged CTRL/PRIO/TIMER to active outputs (irq_en included); reads give mm_err
- 0x04 STATUS RO: [CH_W-1:0] active_channel, [8 +: N_CH] signal_present (both sampled at read)
- 0x05 EVENT W1C: [i] signal-loss on channel i (signal_present[i] 1→0), [8+i] counter i reached saturation
- 0x06 IRQ_MASK RW: same bit layout as EVENT
- 0x07 CNT_CLR WO: bit i=1 clears error counter i
- 0x10+i ERRCNT[i] RO, i<N_CH: [CNT_W-1:0] count
- All other addresses unmapped.

Rules:
- Staged registers are never visible on config outputs until COMMIT.
- Error counter: +1 per error_inc pulse, saturates at 2^CNT_W-1 (no wrap). Clear and increment same cycle → counter = 1. Saturation event sets on the increment that reaches max.
- Signal-loss detect: registered prev of signal_present, reset to 0 (no event after reset even if input starts at 1 then drops — first drop after a sampled 1 does set).
- EVENT: hardware set and W1C clear of the same bit in the same cycle → bit stays 1.
- irq = active irq_en & |(EVENT & IRQ_MASK), registered.
- Write and read in the same cycle are both performed; read of the written address returns the old value.
- Reset: staged and active CTRL/PRIO = 0, TIMER = TIMER_DEF, EVENT/MASK/counters = 0, mm_rdata = 0, mm_rdata_valid/mm_err/valid_config/irq = 0.

## Timing
- Read at edge E → mm_rdata and mm_rdata_valid at E+1 (valid one cycle); mm_rdata holds otherwise.
- Unmapped/WO read: mm_rdata = 0, mm_rdata_valid = 1, mm_err = 1 at E+1.
- Write to RO/unmapped: no state change, mm_err = 1 at E+1.
- COMMIT write at edge E: active outputs change at E; valid_config high for cycle E..E+1 only.
- signal_present drop sampled at edge E → EVENT bit set at E+1 edge; irq high one edge later.
- rst assertion mid-operation clears everything immediately, including pending read response.

## Test plan
- Reset: after release, reset_timer = 1000000, all other outputs 0; read 0x02 → 0x000F4240 one cycle later with valid.
- Stage/commit: write CTRL=0x0000_0023, PRIO=0x0000_0E4 → outputs unchanged; write 0x03 → manual_channel=2, fallback/manual=1, channel_priority=0xE4, valid_config one-cycle pulse.
- Counter: 300 error_inc pulses on ch1 (CNT_W=8) → ERRCNT[1]=255, EVENT[9]=1; CNT_CLR bit1 coincident with error_inc[1] → ERRCNT[1]=1.
- IRQ: MASK=0x1, irq_en committed; drop signal_present[0] → EVENT[0]=1, irq=1 two cycles after drop; W1C 0x1 → irq falls; W1C coinciding with new drop keeps bit set.
- Bus errors: read 0x08 → rdata 0, valid+mm_err; write 0x04 → mm_err, STATUS unchanged.
- Reset mid-read: assert rst the cycle after mm_read_en → no mm_rdata_valid pulse, all outputs at reset values.

Source files
------------

// File: rtl/qos_csr_bank.sv
// qos_csr_bank: host CSR block for the TS QoS core, with staged/committed config, saturating error counters, W1C events and a maskable irq
module qos_csr_bank #(
  parameter int N_CH      = 4,
  parameter int CH_W      = 3,
  parameter int CNT_W     = 8,
  parameter int TIMER_W   = 20,
  parameter int TIMER_DEF = 1000000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   mm_write_en,
  input  logic                   mm_read_en,
  input  logic [7:0]             mm_addr,
  input  logic [31:0]            mm_wdata,
  output logic [31:0]            mm_rdata,
  output logic                   mm_rdata_valid,
  output logic                   mm_err,
  output logic                   fallback_enable,
  output logic                   manual_enable,
  output logic [CH_W-1:0]        manual_channel,
  output logic [N_CH*CH_W-1:0]   channel_priority,
  output logic [TIMER_W-1:0]     reset_timer,
  output logic                   valid_config,
  output logic                   irq,
  input  logic [CH_W-1:0]        active_channel,
  input  logic [N_CH-1:0]        signal_present,
  input  logic [N_CH-1:0]        error_inc
);
  localparam logic [CNT_W-1:0]   CMAX = '1;
  localparam logic [TIMER_W-1:0] TDEF = TIMER_W'(TIMER_DEF);
  logic                 r_fb_s, r_man_s, r_ien_s, r_fb_a, r_man_a, r_ien_a;
  logic                 r_vcfg, r_irq, r_rvalid, r_err;
  logic [CH_W-1:0]      r_mch_s, r_mch_a;
  logic [N_CH*CH_W-1:0] r_prio_s, r_prio_a;
  logic [TIMER_W-1:0]   r_tmr_s, r_tmr_a;
  logic [31:0]          r_rdata, w_rdata;
  logic                 w_rd_ok, w_wr_ok, w_commit, w_w1c;
  logic [N_CH-1:0]      r_ev_loss, r_ev_sat, r_mk_loss, r_mk_sat, r_sp, r_sp_d;
  logic [N_CH-1:0]      w_clr, w_sat_set, w_loss_set, w_w1c_l, w_w1c_s;
  logic [CNT_W-1:0]     r_cnt [N_CH];
  logic [CNT_W-1:0]     w_nxt [N_CH];

  assign w_wr_ok    = mm_addr < 8'h08 && mm_addr != 8'h04;
  assign w_commit   = mm_write_en && mm_addr == 8'h03;
  assign w_w1c      = mm_write_en && mm_addr == 8'h05;
  assign w_w1c_l    = w_w1c ? mm_wdata[N_CH-1:0] : '0;
  assign w_w1c_s    = w_w1c ? mm_wdata[8 +: N_CH] : '0;
  assign w_clr      = (mm_write_en && mm_addr == 8'h07) ? mm_wdata[N_CH-1:0] : '0;
  // signal_present is registered once before edge detection, so a drop lands in EVENT one edge after it is sampled
  assign w_loss_set = r_sp_d & ~r_sp;

  always_comb begin
    for (int k = 0; k < N_CH; k++) begin
      w_nxt[k]     = w_clr[k] ? CNT_W'(error_inc[k]) :
                     (error_inc[k] && r_cnt[k] != CMAX) ? r_cnt[k] + 1'b1 : r_cnt[k];
      w_sat_set[k] = error_inc[k] && w_nxt[k] == CMAX && (w_clr[k] || r_cnt[k] != CMAX);
    end
  end

  always_comb begin
    w_rdata = '0;
    w_rd_ok = 1'b1;
    case (mm_addr)
      8'h00: begin
        w_rdata[2:0]      = {r_ien_s, r_man_s, r_fb_s};
        w_rdata[4 +: CH_W] = r_mch_s;
      end
      8'h01: w_rdata[N_CH*CH_W-1:0] = r_prio_s;
      8'h02: w_rdata[TIMER_W-1:0]   = r_tmr_s;
      8'h04: begin
        w_rdata[CH_W-1:0]  = active_channel;
        w_rdata[8 +: N_CH] = signal_present;
      end
      8'h05: begin
        w_rdata[N_CH-1:0]  = r_ev_loss;
        w_rdata[8 +: N_CH] = r_ev_sat;
      end
      8'h06: begin
        w_rdata[N_CH-1:0]  = r_mk_loss;
        w_rdata[8 +: N_CH] = r_mk_sat;
      end
      default: w_rd_ok = 1'b0;
    endcase
    for (int k = 0; k < N_CH; k++) begin
      if (mm_addr == 8'(16 + k)) begin
        w_rdata = 32'(r_cnt[k]);
        w_rd_ok = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rdata  <= '0;
      r_rvalid <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_rvalid <= mm_read_en;
      r_err    <= (mm_read_en && !w_rd_ok) || (mm_write_en && !w_wr_ok);
      if (mm_read_en) r_rdata <= w_rd_ok ? w_rdata : '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      {r_fb_s, r_man_s, r_ien_s, r_fb_a, r_man_a, r_ien_a, r_vcfg} <= '0;
      r_mch_s  <= '0;
      r_mch_a  <= '0;
      r_prio_s <= '0;
      r_prio_a <= '0;
      r_tmr_s  <= TDEF;
      r_tmr_a  <= TDEF;
    end else begin
      if (mm_write_en && mm_addr == 8'h00) begin
        {r_ien_s, r_man_s, r_fb_s} <= mm_wdata[2:0];
        r_mch_s <= mm_wdata[4 +: CH_W];
      end
      if (mm_write_en && mm_addr == 8'h01) r_prio_s <= mm_wdata[N_CH*CH_W-1:0];
      if (mm_write_en && mm_addr == 8'h02) r_tmr_s <= mm_wdata[TIMER_W-1:0];
      if (w_commit) begin
        {r_ien_a, r_man_a, r_fb_a} <= {r_ien_s, r_man_s, r_fb_s};
        r_mch_a  <= r_mch_s;
        r_prio_a <= r_prio_s;
        r_tmr_a  <= r_tmr_s;
      end
      r_vcfg <= w_commit;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sp      <= '0;
      r_sp_d    <= '0;
      r_ev_loss <= '0;
      r_ev_sat  <= '0;
      r_mk_loss <= '0;
      r_mk_sat  <= '0;
      r_irq     <= 1'b0;
      r_cnt     <= '{default: '0};
    end else begin
      r_sp      <= signal_present;
      r_sp_d    <= r_sp;
      // a hardware set wins over a simultaneous W1C of the same bit
      r_ev_loss <= (r_ev_loss & ~w_w1c_l) | w_loss_set;
      r_ev_sat  <= (r_ev_sat & ~w_w1c_s) | w_sat_set;
      if (mm_write_en && mm_addr == 8'h06) begin
        r_mk_loss <= mm_wdata[N_CH-1:0];
        r_mk_sat  <= mm_wdata[8 +: N_CH];
      end
      r_irq     <= r_ien_a && |((r_ev_loss & r_mk_loss) | (r_ev_sat & r_mk_sat));
      for (int k = 0; k < N_CH; k++) r_cnt[k] <= w_nxt[k];
    end
  end

  assign mm_rdata         = r_rdata;
  assign mm_rdata_valid   = r_rvalid;
  assign mm_err           = r_err;
  assign fallback_enable  = r_fb_a;
  assign manual_enable    = r_man_a;
  assign manual_channel   = r_mch_a;
  assign channel_priority = r_prio_a;
  assign reset_timer      = r_tmr_a;
  assign valid_config     = r_vcfg;
  assign irq              = r_irq;
endmodule

// File: tb/tb_qos_csr_bank.sv
// tb_qos_csr_bank: scenario tasks for qos_csr_bank; read responses are checked against a queue of expected values
module tb_qos_csr_bank;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        mm_write_en, mm_read_en;
  logic [7:0]  mm_addr;
  logic [31:0] mm_wdata, mm_rdata;
  logic        mm_rdata_valid, mm_err;
  logic        fallback_enable, manual_enable, valid_config, irq;
  logic [2:0]  manual_channel, active_channel;
  logic [11:0] channel_priority;
  logic [19:0] reset_timer;
  logic [3:0]  signal_present, error_inc;
  logic [32:0] q[$];
  int          total = 0;
  int          bad = 0;

  qos_csr_bank dut (
    .clk(clk), .rst(rst_n), .mm_write_en(mm_write_en), .mm_read_en(mm_read_en),
    .mm_addr(mm_addr), .mm_wdata(mm_wdata), .mm_rdata(mm_rdata),
    .mm_rdata_valid(mm_rdata_valid), .mm_err(mm_err),
    .fallback_enable(fallback_enable), .manual_enable(manual_enable),
    .manual_channel(manual_channel), .channel_priority(channel_priority),
    .reset_timer(reset_timer), .valid_config(valid_config), .irq(irq),
    .active_channel(active_channel), .signal_present(signal_present), .error_inc(error_inc)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1, "watchdog");
  end

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    mm_write_en = 1'b1; mm_addr = a; mm_wdata = d;
    @(negedge clk);
    mm_write_en = 1'b0;
  endtask

  task automatic rd(input logic [7:0] a, input logic [31:0] ed, input logic ee, input string nm);
    logic [32:0] e;
    q.push_back({ee, ed});
    mm_read_en = 1'b1; mm_addr = a;
    @(negedge clk);
    mm_read_en = 1'b0;
    for (int c = 0; c < 4 && !mm_rdata_valid; c++) @(negedge clk);
    e = q.pop_front();
    total++;
    if (mm_rdata_valid !== 1'b1) begin
      bad++; $display("FAIL %s: rdata_valid=%b expected 1 (timeout)", nm, mm_rdata_valid);
    end else begin
      if (mm_rdata !== e[31:0]) begin bad++; $display("FAIL %s: rdata=%h expected %h", nm, mm_rdata, e[31:0]); end
      total++;
      if (mm_err !== e[32]) begin bad++; $display("FAIL %s: mm_err=%b expected %b", nm, mm_err, e[32]); end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b1; mm_write_en = 0; mm_read_en = 0; mm_addr = 0; mm_wdata = 0;
    active_channel = 0; signal_present = 0; error_inc = 0;
    #3 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    total++; if (reset_timer !== 20'd1000000) begin bad++; $display("FAIL rst_timer: got %0d expected 1000000", reset_timer); end
    total++;
    if ({fallback_enable, manual_enable, manual_channel, channel_priority, valid_config, irq, mm_rdata, mm_rdata_valid, mm_err} !== '0) begin
      bad++; $display("FAIL rst_outs: fb=%b man=%b ch=%h prio=%h vc=%b irq=%b rdata=%h rv=%b err=%b expected all 0",
        fallback_enable, manual_enable, manual_channel, channel_priority, valid_config, irq, mm_rdata, mm_rdata_valid, mm_err);
    end
    rd(8'h02, 32'h000F4240, 1'b0, "rst_rd_timer");
  endtask

  task automatic test_stage_commit();
    wr(8'h00, 32'h0000_0023);
    wr(8'h01, 32'h0000_00E4);
    wr(8'h02, 32'hFFF1_2345);
    total++;
    if ({fallback_enable, manual_enable, manual_channel, channel_priority, valid_config} !== '0 || reset_timer !== 20'd1000000) begin
      bad++; $display("FAIL staged_hidden: fb=%b man=%b ch=%h prio=%h timer=%h vc=%b expected unchanged",
        fallback_enable, manual_enable, manual_channel, channel_priority, reset_timer, valid_config);
    end
    rd(8'h00, 32'h23, 1'b0, "rd_ctrl");
    rd(8'h02, 32'h12345, 1'b0, "rd_timer_masked");
    wr(8'h03, 32'h0);
    total++;
    if ({fallback_enable, manual_enable, manual_channel, channel_priority, reset_timer, valid_config} !== {1'b1, 1'b1, 3'd2, 12'h0E4, 20'h12345, 1'b1}) begin
      bad++; $display("FAIL commit: fb=%b man=%b ch=%0d prio=%h timer=%h vc=%b expected 1 1 2 0e4 12345 1",
        fallback_enable, manual_enable, manual_channel, channel_priority, reset_timer, valid_config);
    end
    @(negedge clk);
    total++; if (valid_config !== 1'b0) begin bad++; $display("FAIL vc_pulse: valid_config=%b expected 0", valid_config); end
  endtask

  task automatic test_counter();
    for (int k = 0; k < 300; k++) begin error_inc = 4'b0010; @(negedge clk); end
    error_inc = 4'b0000;
    rd(8'h11, 32'd255, 1'b0, "cnt_sat");
    rd(8'h10, 32'd0, 1'b0, "cnt_other");
    rd(8'h05, 32'h200, 1'b0, "ev_sat");
    mm_write_en = 1'b1; mm_addr = 8'h07; mm_wdata = 32'h2; error_inc = 4'b0010;
    @(negedge clk);
    mm_write_en = 1'b0; error_inc = 4'b0000;
    rd(8'h11, 32'd1, 1'b0, "cnt_clr_inc");
    wr(8'h05, 32'h200);
    rd(8'h05, 32'h0, 1'b0, "ev_w1c_sat");
  endtask

  task automatic test_irq();
    wr(8'h06, 32'h1);
    wr(8'h00, 32'h27);
    wr(8'h03, 32'h0);
    signal_present = 4'b0001;
    repeat (3) @(negedge clk);
    signal_present = 4'b0000;
    @(negedge clk);
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL irq_e0: irq=%b expected 0", irq); end
    @(negedge clk);
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL irq_e1: irq=%b expected 0", irq); end
    @(negedge clk);
    total++; if (irq !== 1'b1) begin bad++; $display("FAIL irq_e2: irq=%b expected 1", irq); end
    rd(8'h05, 32'h1, 1'b0, "ev_loss");
    wr(8'h05, 32'h1);
    @(negedge clk);
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL irq_clear: irq=%b expected 0", irq); end
    signal_present = 4'b0001;
    repeat (3) @(negedge clk);
    signal_present = 4'b0000;
    @(negedge clk);
    wr(8'h05, 32'h1);
    rd(8'h05, 32'h1, 1'b0, "ev_set_wins");
    total++; if (irq !== 1'b1) begin bad++; $display("FAIL irq_set_wins: irq=%b expected 1", irq); end
  endtask

  task automatic test_bus_err();
    active_channel = 3'd5; signal_present = 4'b1010;
    wr(8'h04, 32'hFFFF_FFFF);
    total++; if (mm_err !== 1'b1) begin bad++; $display("FAIL wr_ro_err: mm_err=%b expected 1", mm_err); end
    wr(8'h20, 32'h1);
    total++; if (mm_err !== 1'b1) begin bad++; $display("FAIL wr_unmapped_err: mm_err=%b expected 1", mm_err); end
    wr(8'h06, 32'h1);
    total++; if (mm_err !== 1'b0) begin bad++; $display("FAIL wr_ok_err: mm_err=%b expected 0", mm_err); end
    rd(8'h04, 32'h0000_0A05, 1'b0, "status");
    rd(8'h08, 32'h0, 1'b1, "rd_unmapped");
    rd(8'h03, 32'h0, 1'b1, "rd_commit_wo");
    rd(8'h07, 32'h0, 1'b1, "rd_cntclr_wo");
    rd(8'h13, 32'h0, 1'b0, "rd_cnt_last");
    rd(8'h14, 32'h0, 1'b1, "rd_cnt_beyond");
  endtask

  task automatic test_reset_mid_read();
    mm_read_en = 1'b1; mm_addr = 8'h00;
    @(posedge clk);
    #1 rst_n = 1'b0; mm_read_en = 1'b0;
    @(negedge clk);
    total++;
    if ({mm_rdata_valid, mm_err, mm_rdata, irq, valid_config, fallback_enable, manual_enable, manual_channel, channel_priority} !== '0) begin
      bad++; $display("FAIL rst_mid_outs: rv=%b err=%b rdata=%h irq=%b vc=%b fb=%b man=%b ch=%h prio=%h expected all 0",
        mm_rdata_valid, mm_err, mm_rdata, irq, valid_config, fallback_enable, manual_enable, manual_channel, channel_priority);
    end
    total++; if (reset_timer !== 20'd1000000) begin bad++; $display("FAIL rst_mid_timer: got %0d expected 1000000", reset_timer); end
    @(negedge clk);
    total++; if (mm_rdata_valid !== 1'b0) begin bad++; $display("FAIL rst_mid_valid: rdata_valid=%b expected 0", mm_rdata_valid); end
    rst_n = 1'b1;
    @(negedge clk);
    rd(8'h00, 32'h0, 1'b0, "rst_mid_ctrl");
    rd(8'h11, 32'h0, 1'b0, "rst_mid_cnt");
    rd(8'h06, 32'h0, 1'b0, "rst_mid_mask");
  endtask

  initial begin
    test_reset();
    test_stage_commit();
    test_counter();
    test_irq();
    test_bus_err();
    test_reset_mid_read();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
